// File: rtl/proj_fm_ram_ctrl.sv
// proj_fm_ram_ctrl: fill/drain sequencer for the single-port projection
// feature-map RAM (ENTRIES x DATA_BITS, one-cycle registered read).
// A fill phase writes producer beats to addresses 0.. in order, then a drain
// phase reads them back to the consumer through a 2-entry output buffer.
// The buffer head is bypassed from the RAM read port when empty, so the first
// beat appears one cycle after the drain starts and a ready consumer sees one
// beat per cycle.
// Optional feature macro: PROJ_FM_CTRL_REPLAY_EN (re-drain the retained
// contents from IDLE without a refill).
module proj_fm_ram_ctrl #(
  parameter int ENTRIES   = 8,
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = $clog2(ENTRIES)
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic                 in_start,
  input  logic                 in_abort,
  input  logic                 in_replay,
  input  logic                 in_wr_valid,
  input  logic [DATA_BITS-1:0] in_wr_data,
  input  logic                 in_wr_last,
  output logic                 out_wr_ready,
  output logic                 out_rd_valid,
  output logic [DATA_BITS-1:0] out_rd_data,
  output logic                 out_rd_last,
  input  logic                 in_rd_ready,
  output logic [ADDR_BITS-1:0] out_ram_addr,
  output logic                 out_ram_we,
  output logic [DATA_BITS-1:0] out_ram_wdata,
  input  logic [DATA_BITS-1:0] in_ram_rdata,
  output logic [ADDR_BITS:0]   out_count,
  output logic                 out_busy,
  output logic                 out_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(ENTRIES - 1);
  localparam logic [ADDR_BITS-1:0] ADDR_ONE  = {{(ADDR_BITS-1){1'b0}}, 1'b1};
  localparam logic [ADDR_BITS:0]   CNT_ONE   = {{ADDR_BITS{1'b0}}, 1'b1};
  localparam logic [ADDR_BITS:0]   CNT_ZERO  = {(ADDR_BITS+1){1'b0}};

  state_t state;
  state_t state_nxt;

  // Sequential datapath state
  logic [ADDR_BITS-1:0] waddr;
  logic [ADDR_BITS:0]   count;
  logic [ADDR_BITS:0]   raddr;          // next read index, 0..count
  logic                 inflight;       // read issued last cycle, data on in_ram_rdata now
  logic                 inflight_last;  // that read was for address count-1
  logic [DATA_BITS-1:0] fb_data [2];
  logic                 fb_last [2];
  logic                 rd_ptr;
  logic                 wr_ptr;
  logic [1:0]           occ;
  logic                 done;

  // Combinational control
  logic                 wr_beat;
  logic                 fill_end;
  logic                 head_valid;
  logic [DATA_BITS-1:0] head_data;
  logic                 head_last;
  logic                 pop;
  logic                 issue;
  logic                 push_buf;
  logic                 pop_buf;
  logic                 replay_go;
  logic [2:0]           avail;

  // Replay request qualifier; tied off when the feature is not built
  always_comb begin
`ifdef PROJ_FM_CTRL_REPLAY_EN
    replay_go = in_replay && (count != CNT_ZERO);
`else
    replay_go = in_replay & 1'b0;
`endif
  end

  // Handshake, buffer-head and read-issue decisions for the current cycle
  always_comb begin
    wr_beat  = (state == ST_FILL) && in_wr_valid;
    fill_end = wr_beat && (in_wr_last || (waddr == LAST_ADDR));

    head_valid = (state == ST_DRAIN) && ((occ != 2'd0) || inflight);
    if (occ != 2'd0) begin
      head_data = fb_data[rd_ptr];
      head_last = fb_last[rd_ptr];
    end else begin
      head_data = in_ram_rdata;
      head_last = inflight_last;
    end

    pop = head_valid && in_rd_ready;

    // Entries held or arriving, minus the one leaving this cycle
    avail = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    issue = (state == ST_DRAIN) && (raddr < count) && (avail < 3'd2);

    // A returning word that is consumed straight off the bypass is not stored
    push_buf = inflight && !((occ == 2'd0) && pop);
    pop_buf  = pop && (occ != 2'd0);
  end

  // State register
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort overrides every other request
  always_comb begin
    state_nxt = state;
    if (in_abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_start) begin
            state_nxt = ST_FILL;
          end else if (replay_go) begin
            state_nxt = ST_DRAIN;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_FILL: begin
          if (fill_end) begin
            state_nxt = ST_DRAIN;
          end else begin
            state_nxt = ST_FILL;
          end
        end
        ST_DRAIN: begin
          if (pop && head_last) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_DRAIN;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Address counters, fill count, read tracking and output buffer
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      waddr         <= {ADDR_BITS{1'b0}};
      count         <= CNT_ZERO;
      raddr         <= CNT_ZERO;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      occ           <= 2'd0;
      done          <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fb_data[i] <= {DATA_BITS{1'b0}};
        fb_last[i] <= 1'b0;
      end
    end else begin
      done <= 1'b0;
      if (in_abort) begin
        // Drop everything in flight; a beat accepted this cycle still counts
        inflight      <= 1'b0;
        inflight_last <= 1'b0;
        rd_ptr        <= 1'b0;
        wr_ptr        <= 1'b0;
        occ           <= 2'd0;
        if (wr_beat) begin
          waddr <= waddr + ADDR_ONE;
          count <= count + CNT_ONE;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (in_start) begin
              waddr <= {ADDR_BITS{1'b0}};
              count <= CNT_ZERO;
              raddr <= CNT_ZERO;
            end else if (replay_go) begin
              raddr <= CNT_ZERO;
            end
          end
          ST_FILL: begin
            if (wr_beat) begin
              waddr <= waddr + ADDR_ONE;
              count <= count + CNT_ONE;
            end
            if (fill_end) begin
              raddr <= CNT_ZERO;
            end
          end
          ST_DRAIN: begin
            if (pop && head_last) begin
              done          <= 1'b1;
              inflight      <= 1'b0;
              inflight_last <= 1'b0;
              rd_ptr        <= 1'b0;
              wr_ptr        <= 1'b0;
              occ           <= 2'd0;
            end else begin
              inflight      <= issue;
              inflight_last <= issue && (raddr == (count - CNT_ONE));
              if (issue) begin
                raddr <= raddr + CNT_ONE;
              end
              if (push_buf) begin
                fb_data[wr_ptr] <= in_ram_rdata;
                fb_last[wr_ptr] <= inflight_last;
                wr_ptr          <= ~wr_ptr;
              end
              if (pop_buf) begin
                rd_ptr <= ~rd_ptr;
              end
              case ({push_buf, pop_buf})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
              endcase
            end
          end
          default: begin
            occ <= 2'd0;
          end
        endcase
      end
    end
  end

  // RAM port and stream outputs; address rests at 0 when idle
  always_comb begin
    out_ram_we    = 1'b0;
    out_ram_addr  = {ADDR_BITS{1'b0}};
    out_ram_wdata = {DATA_BITS{1'b0}};
    if (wr_beat) begin
      out_ram_we    = 1'b1;
      out_ram_addr  = waddr;
      out_ram_wdata = in_wr_data;
    end else if (issue) begin
      out_ram_addr = raddr[ADDR_BITS-1:0];
    end else begin
      out_ram_addr = {ADDR_BITS{1'b0}};
    end

    out_wr_ready = (state == ST_FILL);
    out_rd_valid = head_valid;
    if (head_valid) begin
      out_rd_data = head_data;
      out_rd_last = head_last;
    end else begin
      out_rd_data = {DATA_BITS{1'b0}};
      out_rd_last = 1'b0;
    end

    out_count = count;
    out_busy  = (state != ST_IDLE);
    out_done  = done;
  end

endmodule

// File: doc/proj_fm_ram_ctrl.md
Name: proj_fm_ram_ctrl

Overview:
- Sequencer for the single-port projection feature-map RAM (ENTRIES x DATA_BITS, 1-cycle registered read) used in the MinHash datapath.
- Owns the RAM address, write-enable and write-data; runs a fill phase from a producer stream, then a drain phase to a consumer stream.
- Both streams use valid/ready handshakes; drain sustains 1 beat/cycle through a 2-entry output buffer.

Parameters:
- ENTRIES, 8, RAM depth; must be >= 2.
- DATA_BITS, 8, data width.
- ADDR_BITS, $clog2(ENTRIES), RAM address width (derived; do not override).

Ports:
- in_clk  input  1  clock, rising edge
- in_rst  input  1  asynchronous active-high reset
- in_start  input  1  pulse: begin fill (accepted only in IDLE)
- in_abort  input  1  synchronous abort to IDLE from any state
- in_replay  input  1  pulse: re-drain without refill (optional feature only)
- in_wr_valid  input  1  producer beat valid
- in_wr_data  input  DATA_BITS  producer beat data
- in_wr_last  input  1  producer final beat
- out_wr_ready  output  1  controller accepts producer beat
- out_rd_valid  output  1  consumer beat valid
- out_rd_data  output  DATA_BITS  consumer beat data
- out_rd_last  output  1  final drain beat
- in_rd_ready  input  1  consumer accepts beat
- out_ram_addr  output  ADDR_BITS  RAM address
- out_ram_we  output  1  RAM write enable
- out_ram_wdata  output  DATA_BITS  RAM write data
- in_ram_rdata  input  DATA_BITS  RAM read data, valid the cycle after the address
- out_count  output  ADDR_BITS+1  entries written in last fill
- out_busy  output  1  state != IDLE
- out_done  output  1  one-cycle pulse after last drain beat accepted

Behaviour:
- Reset (in_rst high, asynchronous): state IDLE; all outputs 0; address counters, count and output buffer cleared.
- States: IDLE, FILL, DRAIN.
- IDLE: in_start -> FILL; write address 0; count 0. Otherwise hold.
- FILL: out_wr_ready=1.
  - Each beat (valid & ready) drives out_ram_we=1, out_ram_addr=waddr, out_ram_wdata=in_wr_data combinationally in the same cycle; waddr+1; count+1.
  - Leave to DRAIN when the accepted beat has in_wr_last=1, or is the ENTRIES-th beat (waddr==ENTRIES-1). The ENTRIES-th beat ends the fill regardless of in_wr_last.
  - A one-beat fill gives count=1.
- DRAIN: out_wr_ready=0; out_ram_we=0.
  - Reads of addresses 0..count-1 are issued in order.
  - A read issues in any cycle where (buffer occupancy + in-flight reads - pop this cycle) < 2 and reads remain. Returned data is pushed into the 2-entry buffer next cycle.
  - Head of buffer drives out_rd_valid/out_rd_data. out_rd_last=1 on the beat from address count-1.
  - Timing: entering DRAIN at edge T issues address 0 in cycle T; out_rd_valid=1 in cycle T+1. With in_rd_ready held high, one beat per cycle, no bubbles.
  - out_rd_valid/out_rd_data stay stable while in_rd_ready=0.
  - After the last beat is accepted: IDLE next edge, out_done=1 for that one cycle.
- out_ram_addr is 0 when no write or read is active.
- in_abort (any state): IDLE next edge; buffer and in-flight reads discarded; out_rd_valid=0; count retained; no out_done.
- in_abort has priority over in_start/in_replay.
- in_start outside IDLE: ignored. in_wr_valid outside FILL: ignored (ready=0).
- Same-cycle fill end and in_abort: abort wins; count includes the accepted beat.

Optional Feature:
- Macro: PROJ_FM_CTRL_REPLAY_EN.
- Defined: in IDLE with count!=0, in_replay -> DRAIN over 0..count-1 using the retained count. in_start takes priority over in_replay.
- Undefined: in_replay is ignored; the port is still present.

Test Plan:
- Full fill: start, 8 beats data 0..7, wr_last=0 -> RAM writes addr 0..7; DRAIN after beat 8; drain with rd_ready=1 yields 0..7 on consecutive cycles; last on 7; done pulse; count=8.
- Short fill: wr_last on beat 3 (data A,B,C) -> count=3; drain yields A,B,C; last on C; then IDLE.
- Backpressure: rd_ready toggles 1,0,0,1... during drain -> order preserved, no duplicates or drops, data stable while stalled.
- Abort mid-drain after 2 beats -> out_rd_valid=0 next cycle; IDLE; no done; a new start refills from addr 0.
- Async reset asserted mid-fill between clock edges -> outputs 0 immediately; state IDLE.
- Replay (macro defined): after a 5-entry drain, replay pulse -> same 5 values re-emitted. Macro undefined -> no activity.
